// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port among requesters,
//            granting bursts of up to MAX_BURST beats.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4,
   localparam int c_id_w    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int c_cnt_w   = $clog2(MAX_BURST) + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic [c_id_w-1:0]             grant_id,
   output logic                          grant_active
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [c_id_w-1:0]   r_grant_id, w_grant_id_nxt;
   logic [c_id_w-1:0]   r_last_grant, w_last_grant_nxt;
   logic                r_grant_active, w_grant_active_nxt;
   logic [c_cnt_w-1:0]  r_beat_cnt, w_beat_cnt_nxt;

   logic                w_any;
   logic [c_id_w-1:0]   w_sel;
   logic                w_g_valid;
   logic                w_g_last;
   logic [DATA_WIDTH-1:0] w_g_data;
   logic                w_transfer;
   logic                w_in_grant;

   assign w_in_grant = (r_state == S_GRANT);

   // Granted requester's signals.
   always_comb begin
      w_g_valid = 1'b0;
      w_g_last  = 1'b0;
      w_g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_id == c_id_w'(i)) begin
            w_g_valid = req_valid[i];
            w_g_last  = req_last[i];
            w_g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Round-robin search: outer loop sets priority, starting just after the last owner.
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_any && (i == (int'(r_last_grant) + k) % NUM_REQ) && req_valid[i]) begin
               w_any = 1'b1;
               w_sel = c_id_w'(i);
            end
         end
      end
   end

   assign w_transfer = w_in_grant && w_g_valid && !fifo_full;

   always_comb begin
      w_state_nxt        = r_state;
      w_grant_id_nxt     = r_grant_id;
      w_grant_active_nxt = r_grant_active;
      w_beat_cnt_nxt     = r_beat_cnt;
      w_last_grant_nxt   = r_last_grant;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt        = S_GRANT;
               w_grant_id_nxt     = w_sel;
               w_grant_active_nxt = 1'b1;
               w_beat_cnt_nxt     = '0;
            end
         end
         S_GRANT: begin
            if (!w_g_valid) begin
               w_state_nxt        = S_IDLE;
               w_last_grant_nxt   = r_grant_id;
               w_grant_active_nxt = 1'b0;
            end else if (w_transfer) begin
               if (w_g_last || (r_beat_cnt == c_cnt_w'(MAX_BURST - 1))) begin
                  w_state_nxt        = S_IDLE;
                  w_last_grant_nxt   = r_grant_id;
                  w_grant_active_nxt = 1'b0;
               end else begin
                  w_beat_cnt_nxt = r_beat_cnt + c_cnt_w'(1);
               end
            end
         end
         default: begin
            w_state_nxt        = S_IDLE;
            w_grant_active_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_grant_id     <= '0;
         r_grant_active <= 1'b0;
         r_beat_cnt     <= '0;
         r_last_grant   <= c_id_w'(NUM_REQ - 1);
      end else begin
         r_state        <= w_state_nxt;
         r_grant_id     <= w_grant_id_nxt;
         r_grant_active <= w_grant_active_nxt;
         r_beat_cnt     <= w_beat_cnt_nxt;
         r_last_grant   <= w_last_grant_nxt;
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = w_in_grant && !fifo_full && (r_grant_id == c_id_w'(i));
      end
   end

   assign fifo_wr_en   = w_transfer;
   assign fifo_data_in = r_grant_active ? w_g_data : '0;
   assign grant_id     = r_grant_id;
   assign grant_active = r_grant_active;

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ requesters. Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a burst of up to MAX_BURST beats, then drives the FIFO's write-enable and data-in. It also honours the FIFO's full flag. It sits directly in front of the team's fifo write port.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, beat width; must match the FIFO's DATA_WIDTH
MAX_BURST, 4, maximum beats per grant before forced re-arbitration (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by valid
req_data  input  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept, combinational
fifo_full  input  1  FIFO full flag
fifo_wr_en  output  1  FIFO write enable, combinational
fifo_data_in  output  DATA_WIDTH  FIFO write data, combinational
grant_id  output  clog2(NUM_REQ) (min 1)  currently granted requester, registered
grant_active  output  1  high in GRANT state, registered

Behaviour:
- Reset (rst=1, async) applies: state=IDLE, grant_id=0, grant_active=0, beat_cnt=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
- Outputs during reset: req_ready=0, fifo_wr_en=0, fifo_data_in=0.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If any req_valid is high, select the first valid requester searching from last_grant+1 upward, modulo NUM_REQ.
  - Next cycle: grant_id = selected requester, grant_active=1, beat_cnt=0, state=GRANT.
  - If no req_valid is high, remain in IDLE.
  - Arbitration latency is exactly 1 cycle from valid to grant. Nothing is accepted in IDLE.
- GRANT, with g = grant_id:
  - req_ready[g] = !fifo_full. All other req_ready bits = 0.
  - Transfer occurs when req_valid[g] && req_ready[g].
  - fifo_wr_en = transfer. fifo_data_in = slice g of req_data when grant_active, else 0.
  - On a transfer with req_last[g]=1 or beat_cnt==MAX_BURST-1: burst ends; next state=IDLE, last_grant=g, grant_active=0.
  - On a transfer otherwise: beat_cnt increments.
  - If req_valid[g]=0 (and so no transfer): burst ends; next state=IDLE, last_grant=g.
  - If fifo_full=1 and req_valid[g]=1: hold GRANT. No transfer, beat_cnt unchanged, no timeout.
- Requester protocol: once req_valid is asserted, it stays high with stable data/last until the transfer. A drop is only legal after a transfer and ends the burst.
- Every burst end inserts one IDLE cycle before the next grant. Maximum throughput is MAX_BURST beats per MAX_BURST+1 cycles.
- Fairness: a continuously requesting requester waits at most (NUM_REQ-1)*(MAX_BURST+1) non-full cycles for its grant.
- fifo_data_in is never written while fifo_full=1. The FIFO's own full check is redundant but harmless.
- beat_cnt is clog2(MAX_BURST)+1 bits wide. It never wraps because the burst ends at MAX_BURST-1.
- Reset asserted mid-burst: all state clears immediately (asynchronously). The partial burst is abandoned. No FIFO write occurs in the cycle of the reset edge.

Test Plan:
- Reset then single requester: req_valid=0001, data 0x11,0x22,0x33, last on 0x33 -> grant_active high on cycle 2; fifo_wr_en on 3 consecutive cycles with data 0x11,0x22,0x33; then IDLE; grant_id=0.
- Burst cap: requester 2 holds valid for 10 beats, MAX_BURST=4 -> writes grouped 4,4,2 with one idle cycle between groups; grant_id=2 throughout.
- Round robin: all four valid continuously, each sends 4-beat bursts -> grant order 0,1,2,3,0; 16 writes in 20 cycles.
- Full backpressure: fifo_full=1 for 5 cycles mid-burst after beat 2 -> req_ready=0 and fifo_wr_en=0 for those 5 cycles; beats 3-4 written after full clears; beat_cnt preserved.
- Valid drop: requester 1 sends 2 beats then drops valid while requester 3 is waiting -> grant returns to IDLE, then grant_id=3 two cycles after the drop.
- Async reset mid-burst: assert rst between clock edges during beat 2 of 4 -> grant_active=0 and req_ready=0 immediately; after release, the next grant goes to requester 0 if it is valid.
